// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and the clog2 helper.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package fifo_pkg;

  // Default word width and capacity for FIFO instances.
  localparam int C_FIFO_WIDTH_DEF = 64;
  localparam int C_FIFO_DEPTH_DEF = 512;

  // Ceiling log2. Used to size pointers and counters.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/xilinx_simple_dual_port_no_change_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no read reset.
// Latency: 1 cycle read (LOW_LATENCY), 2 cycles (HIGH_PERFORMANCE).
// Backpressure: none; with fifo_fwft high the read register holds while i_enb is low.
module xilinx_simple_dual_port_no_change_ram
  import fifo_pkg::*;
#(
  parameter int    C_RAM_WIDTH = 64,
  parameter int    C_RAM_DEPTH = 512,
  parameter string C_RAM_PERF  = "LOW_LATENCY",
  localparam int   LP_AW       = clog2(C_RAM_DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_wea,
  input  logic [LP_AW-1:0]       i_addra,
  input  logic [C_RAM_WIDTH-1:0] i_dina,
  input  logic                   i_enb,
  input  logic [LP_AW-1:0]       i_addrb,
  input  logic                   fifo_fwft,
  output logic [C_RAM_WIDTH-1:0] o_doutb
);

  logic [C_RAM_WIDTH-1:0] r_mem [C_RAM_DEPTH];
  logic [C_RAM_WIDTH-1:0] r_rd_dat;
  logic                   w_rd_load;

  // In FWFT mode the read register only moves on an explicit read, so the
  // presented word stays put until the consumer asks for the next one.
  assign w_rd_load = i_enb || !fifo_fwft;

  // Write port: storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_wea) r_mem[i_addra] <= i_dina;
  end

  // Read port: registered read from the addressed word.
  always_ff @(posedge i_clk) begin
    if (w_rd_load) r_rd_dat <= r_mem[i_addrb];
  end

  if (C_RAM_PERF == "HIGH_PERFORMANCE") begin : g_hp
    logic                   r_load_d;
    logic [C_RAM_WIDTH-1:0] r_out_dat;

    // Second pipeline stage follows the first stage's load, one cycle later.
    always_ff @(posedge i_clk) begin
      r_load_d <= w_rd_load;
      if (r_load_d) r_out_dat <= r_rd_dat;
    end

    assign o_doutb = r_out_dat;
  end else begin : g_ll
    assign o_doutb = r_rd_dat;
  end

endmodule

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO over a registered-read RAM.
// Latency: push to an empty FIFO shows on dataout two edges later; pops sustain one word per cycle.
// Backpressure: pushes refused while full (overflow pulse), pops refused while empty (underflow pulse).
module sync_fwft_fifo
  import fifo_pkg::*;
#(
  parameter int  C_FIFO_WIDTH = C_FIFO_WIDTH_DEF,
  parameter int  C_FIFO_DEPTH = C_FIFO_DEPTH_DEF,
  localparam int LP_PW        = clog2(C_FIFO_DEPTH),
  localparam int LP_CW        = LP_PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wren,
  input  logic [C_FIFO_WIDTH-1:0] datain,
  input  logic                    rden,
  output logic [C_FIFO_WIDTH-1:0] dataout,
  output logic                    empty,
  output logic                    full,
  output logic [LP_CW-1:0]        count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam logic [LP_CW-1:0] LP_FULL_CNT = LP_CW'(C_FIFO_DEPTH);

  logic [LP_PW-1:0] r_wr_ptr;
  logic [LP_PW-1:0] r_rd_ptr;
  logic [LP_CW-1:0] r_ram_cnt;   // words in RAM not yet loaded into the output register
  logic [LP_CW-1:0] r_count;     // r_ram_cnt plus the presented head word
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push;
  logic             w_pop;
  logic             w_rd;
  logic [LP_CW-1:0] w_count_nxt;
  logic [LP_CW-1:0] w_ram_cnt_nxt;

  // Accept decisions use the registered flags only, so a same-cycle pop never
  // frees room for a push and a same-cycle push never feeds a pop.
  assign w_push = wren && !r_full;
  assign w_pop  = rden && !r_empty;
  // Refill the output register when it is empty or being consumed. r_ram_cnt
  // excludes this cycle's push, so the read never targets the word being written.
  assign w_rd   = (r_ram_cnt != '0) && (r_empty || w_pop);

  // Next-state occupancy counts.
  always_comb begin
    w_count_nxt   = r_count;
    w_ram_cnt_nxt = r_ram_cnt;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    case ({w_push, w_rd})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + 1'b1;
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - 1'b1;
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase
  end

  // Pointer, occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd)   r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt   <= w_ram_cnt_nxt;
      r_count     <= w_count_nxt;
      r_full      <= (w_count_nxt == LP_FULL_CNT);
      // A read loads a fresh head; a pop without refill leaves nothing presented.
      if (w_rd)       r_empty <= 1'b0;
      else if (w_pop) r_empty <= 1'b1;
      r_overflow  <= wren && r_full;
      r_underflow <= rden && r_empty;
    end
  end

  xilinx_simple_dual_port_no_change_ram #(
    .C_RAM_WIDTH (C_FIFO_WIDTH),
    .C_RAM_DEPTH (C_FIFO_DEPTH),
    .C_RAM_PERF  ("LOW_LATENCY")
  ) u_ram (
    .i_clk     (clk),
    .i_wea     (w_push),
    .i_addra   (r_wr_ptr),
    .i_dina    (datain),
    .i_enb     (w_rd),
    .i_addrb   (r_rd_ptr),
    .fifo_fwft (1'b1),
    .o_doutb   (dataout)
  );

  assign empty     = r_empty;
  assign full      = r_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
